// File: rtl/rect_loader_pkg.sv
// rtl/rect_loader_pkg.sv - shared GPU rectangle-table constants and loader state type
package rect_loader_pkg;

  localparam int COORD_WIDTH    = 16;
  localparam int RECT_COUNT     = 64;
  localparam int WORDS_PER_RECT = 5;

  // Field offsets within one table entry; the CPU-side table writer uses the same layout.
  localparam logic [2:0] FIELD_X     = 3'd0;
  localparam logic [2:0] FIELD_Y     = 3'd1;
  localparam logic [2:0] FIELD_W     = 3'd2;
  localparam logic [2:0] FIELD_H     = 3'd3;
  localparam logic [2:0] FIELD_COLOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } loader_state_e;

endpackage

// File: rtl/rect_loader_if.sv
// rtl/rect_loader_if.sv - control, video-memory read and comparator-bank write signals
interface rect_loader_if #(
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 13,
  parameter int INDEX_WIDTH = 6
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   mem_re;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [COORD_WIDTH-1:0] mem_data;
  logic                   rect_we;
  logic [INDEX_WIDTH-1:0] rect_index;
  logic [COORD_WIDTH-1:0] rect_left;
  logic [COORD_WIDTH-1:0] rect_top;
  logic [COORD_WIDTH-1:0] rect_right;
  logic [COORD_WIDTH-1:0] rect_bottom;
  logic [COORD_WIDTH-1:0] rect_color;

  modport master (
    input  start, mem_data,
    output busy, done, mem_re, mem_addr,
    output rect_we, rect_index, rect_left, rect_top, rect_right, rect_bottom, rect_color
  );

  modport slave (
    output start, mem_data,
    input  busy, done, mem_re, mem_addr,
    input  rect_we, rect_index, rect_left, rect_top, rect_right, rect_bottom, rect_color
  );
endinterface

// File: rtl/rect_loader.sv
// rtl/rect_loader.sv - walks the rectangle table during vblank and writes edge-form
// rectangles into the comparator bank register file
module rect_loader #(
  parameter int COORD_WIDTH = rect_loader_pkg::COORD_WIDTH,
  parameter int RECT_COUNT  = rect_loader_pkg::RECT_COUNT,
  parameter int ADDR_WIDTH  = 13,
  parameter int RECT_BASE   = 0,
  parameter int INDEX_WIDTH = $clog2(RECT_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  rect_loader_if.master bus
);
  import rect_loader_pkg::*;

  localparam int                    N_WORDS   = WORDS_PER_RECT * RECT_COUNT;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(RECT_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RECT_BASE + N_WORDS - 1);

  typedef logic [COORD_WIDTH-1:0] coord_t;

  loader_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [2:0]             phase_q, phase_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  coord_t                 x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic                   we_q, we_d;
  logic                   done_q, done_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  coord_t                 left_q, left_d, top_q, top_d;
  coord_t                 right_q, right_d, bottom_q, bottom_d, color_q, color_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= BASE_ADDR;
      rd_valid_q <= 1'b0;
      phase_q    <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      index_q    <= '0;
      left_q     <= '0;
      top_q      <= '0;
      right_q    <= '0;
      bottom_q   <= '0;
      color_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      we_q       <= we_d;
      done_q     <= done_d;
      index_q    <= index_d;
      left_q     <= left_d;
      top_q      <= top_d;
      right_q    <= right_d;
      bottom_q   <= bottom_d;
      color_q    <= color_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_valid_d = (state_q == ST_FETCH);
    phase_d    = phase_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    index_d    = index_q;
    left_d     = left_q;
    top_d      = top_q;
    right_d    = right_q;
    bottom_d   = bottom_q;
    color_d    = color_q;

    // Memory data lags the address by one cycle; rd_valid_q marks a word on mem_data.
    if (rd_valid_q) begin
      phase_d = phase_q + 3'd1;
      case (phase_q)
        FIELD_X: x_d = bus.mem_data;
        FIELD_Y: y_d = bus.mem_data;
        FIELD_W: w_d = bus.mem_data;
        FIELD_H: h_d = bus.mem_data;
        FIELD_COLOR: begin
          we_d     = 1'b1;
          index_d  = idx_q;
          left_d   = x_q;
          top_d    = y_q;
          right_d  = x_q + w_q;
          bottom_d = y_q + h_q;
          color_d  = bus.mem_data;
          idx_d    = idx_q + INDEX_WIDTH'(1);
          phase_d  = '0;
        end
        default: phase_d = '0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          addr_d  = BASE_ADDR;
          phase_d = '0;
          idx_d   = '0;
        end
      end
      ST_FETCH: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // The only write that can land in DRAIN is the final rectangle.
        if (we_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.mem_re      = (state_q == ST_FETCH);
  assign bus.mem_addr    = addr_q;
  assign bus.done        = done_q;
  assign bus.rect_we     = we_q;
  assign bus.rect_index  = index_q;
  assign bus.rect_left   = left_q;
  assign bus.rect_top    = top_q;
  assign bus.rect_right  = right_q;
  assign bus.rect_bottom = bottom_q;
  assign bus.rect_color  = color_q;

endmodule

// File: tb/tb_rect_loader.sv
// tb/tb_rect_loader.sv - randomized self-checking bench for rect_loader against a table-walk model
module tb_rect_loader;

  localparam int RC   = 2;
  localparam int BASE = 'h100;
  localparam int NW   = 5 * RC;
  localparam int AW   = 13;
  localparam int CW   = 16;
  localparam int IW   = 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  idx;
    logic [15:0] l;
    logic [15:0] t;
    logic [15:0] r;
    logic [15:0] b;
    logic [15:0] c;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rect_loader_if #(.COORD_WIDTH(CW), .ADDR_WIDTH(AW), .INDEX_WIDTH(IW)) bus ();

  rect_loader #(
    .COORD_WIDTH(CW), .RECT_COUNT(RC), .ADDR_WIDTH(AW), .RECT_BASE(BASE), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [15:0] mem [0:8191];
  always @(posedge clk) if (bus.mem_re) bus.mem_data <= mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t         wr_log[$];
  wr_t         exp_wr[$];
  int          done_log[$];
  int          exp_done[$];
  int          re_cyc[$];
  logic [12:0] re_addr[$];
  int          busy_log[$];

  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    wr_t w;
    if (bus.rect_we) begin
      w = {32'(cyc), 8'(bus.rect_index), bus.rect_left, bus.rect_top,
           bus.rect_right, bus.rect_bottom, bus.rect_color};
      wr_log.push_back(w);
    end
    if (bus.done) done_log.push_back(cyc);
    if (bus.mem_re) begin
      re_cyc.push_back(cyc);
      re_addr.push_back(bus.mem_addr);
    end
    if (bus.busy) busy_log.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete(); exp_wr.delete(); done_log.delete(); exp_done.delete();
    re_cyc.delete(); re_addr.delete(); busy_log.delete();
  endtask

  // Reference: each table entry becomes one edge-form write 5i+7 cycles after start.
  function automatic void model_load(input int t0);
    for (int i = 0; i < RC; i++) begin
      wr_t w;
      logic [15:0] x, y, wd, h;
      x  = mem[BASE + 5*i + 0];
      y  = mem[BASE + 5*i + 1];
      wd = mem[BASE + 5*i + 2];
      h  = mem[BASE + 5*i + 3];
      w.cyc = 32'(t0 + 5*i + 7);
      w.idx = 8'(i);
      w.l   = x;
      w.t   = y;
      w.r   = x + wd;
      w.b   = y + h;
      w.c   = mem[BASE + 5*i + 4];
      exp_wr.push_back(w);
    end
    exp_done.push_back(t0 + 5*RC + 3);
  endfunction

  task automatic set_rect(input int i, input logic [15:0] x, y, w, h, c);
    mem[BASE + 5*i + 0] = x;
    mem[BASE + 5*i + 1] = y;
    mem[BASE + 5*i + 2] = w;
    mem[BASE + 5*i + 3] = h;
    mem[BASE + 5*i + 4] = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    tick(2);
    vectors++;
    if ({bus.busy, bus.done, bus.mem_re, bus.rect_we} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000", {bus.busy, bus.done, bus.mem_re, bus.rect_we});
    end
    vectors++;
    if (bus.mem_addr !== 13'(BASE)) begin
      miscompares++;
      $display("FAIL reset_addr got %h want %h", bus.mem_addr, 13'(BASE));
    end
    vectors++;
    if ({bus.rect_index, bus.rect_left, bus.rect_top, bus.rect_right, bus.rect_bottom, bus.rect_color} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0", {bus.rect_index, bus.rect_left, bus.rect_top,
               bus.rect_right, bus.rect_bottom, bus.rect_color});
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int t0;
    set_rect(0, 16'd10, 16'd20, 16'd30, 16'd40, 16'h001F);
    set_rect(1, 16'hFFFB, 16'd0, 16'd5, 16'd1, 16'h03E0);
    clear_logs();
    t0 = cyc;
    model_load(t0);
    pulse_start();
    tick(20);
    vectors++;
    if (wr_log.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL basic_wr_count got %0d want %0d", wr_log.size(), exp_wr.size());
    end
    foreach (exp_wr[j]) if (j < wr_log.size()) begin
      vectors++;
      if (wr_log[j] !== exp_wr[j]) begin
        miscompares++;
        $display("FAIL basic_wr%0d got %h want %h", j, wr_log[j], exp_wr[j]);
      end
    end
    vectors++;
    if (done_log != exp_done) begin
      miscompares++;
      $display("FAIL basic_done got %p want %p", done_log, exp_done);
    end
    vectors++;
    if (re_cyc.size() != NW) begin
      miscompares++;
      $display("FAIL basic_re_count got %0d want %0d", re_cyc.size(), NW);
    end
    foreach (re_cyc[k]) begin
      vectors++;
      if (re_cyc[k] != t0 + 1 + k || re_addr[k] !== 13'(BASE + k)) begin
        miscompares++;
        $display("FAIL basic_re%0d got cyc %0d addr %h want cyc %0d addr %h",
                 k, re_cyc[k] - t0, re_addr[k], 1 + k, 13'(BASE + k));
      end
    end
    vectors++;
    if (busy_log.size() != NW + 2 || busy_log[0] != t0 + 1) begin
      miscompares++;
      $display("FAIL basic_busy got %0d cycles from %0d want %0d from 1",
               busy_log.size(), busy_log.size() > 0 ? busy_log[0] - t0 : -1, NW + 2);
    end
    vectors++;
    if (bus.mem_addr !== 13'(BASE + NW - 1)) begin
      miscompares++;
      $display("FAIL basic_addr_hold got %h want %h", bus.mem_addr, 13'(BASE + NW - 1));
    end
  endtask

  task automatic test_random();
    int t0;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < RC; i++)
        set_rect(i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if (it == 0) begin
        mem[BASE + 0] = 16'h7FFF;
        mem[BASE + 2] = 16'd2;
      end
      clear_logs();
      t0 = cyc;
      model_load(t0);
      pulse_start();
      tick(16 + $urandom_range(0, 3));
      vectors++;
      if (wr_log.size() != exp_wr.size()) begin
        miscompares++;
        $display("FAIL rand%0d_wr_count got %0d want %0d", it, wr_log.size(), exp_wr.size());
      end
      foreach (exp_wr[j]) if (j < wr_log.size()) begin
        vectors++;
        if (wr_log[j] !== exp_wr[j]) begin
          miscompares++;
          $display("FAIL rand%0d_wr%0d got %h want %h", it, j, wr_log[j], exp_wr[j]);
        end
      end
      vectors++;
      if (done_log != exp_done) begin
        miscompares++;
        $display("FAIL rand%0d_done got %p want %p", it, done_log, exp_done);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int t0;
    clear_logs();
    t0 = cyc;
    model_load(t0);
    pulse_start();
    tick(4);
    pulse_start();
    tick(20);
    vectors++;
    if (wr_log.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL busy_start_wr_count got %0d want %0d", wr_log.size(), exp_wr.size());
    end
    foreach (exp_wr[j]) if (j < wr_log.size()) begin
      vectors++;
      if (wr_log[j] !== exp_wr[j]) begin
        miscompares++;
        $display("FAIL busy_start_wr%0d got %h want %h", j, wr_log[j], exp_wr[j]);
      end
    end
    vectors++;
    if (done_log != exp_done) begin
      miscompares++;
      $display("FAIL busy_start_done got %p want %p", done_log, exp_done);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_logs();
    t0 = cyc;
    model_load(t0);
    model_load(t0 + NW + 3);
    pulse_start();
    tick(NW + 2);
    pulse_start();
    tick(NW + 10);
    vectors++;
    if (wr_log.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL b2b_wr_count got %0d want %0d", wr_log.size(), exp_wr.size());
    end
    foreach (exp_wr[j]) if (j < wr_log.size()) begin
      vectors++;
      if (wr_log[j] !== exp_wr[j]) begin
        miscompares++;
        $display("FAIL b2b_wr%0d got %h want %h", j, wr_log[j], exp_wr[j]);
      end
    end
    vectors++;
    if (done_log != exp_done) begin
      miscompares++;
      $display("FAIL b2b_done got %p want %p", done_log, exp_done);
    end
  endtask

  task automatic test_async_reset();
    int t0;
    clear_logs();
    t0 = cyc;
    model_load(t0);
    void'(exp_wr.pop_back());
    exp_done.delete();
    pulse_start();
    tick(8);
    vectors++;
    if ({bus.busy, bus.mem_re} !== 2'b11) begin
      miscompares++;
      $display("FAIL arst_pre got %b want 11", {bus.busy, bus.mem_re});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.mem_re, bus.rect_we} !== 3'b000) begin
      miscompares++;
      $display("FAIL arst_immediate got %b want 000", {bus.busy, bus.mem_re, bus.rect_we});
    end
    tick(2);
    reset = 1'b0;
    tick(20);
    vectors++;
    if (wr_log.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL arst_wr_count got %0d want %0d", wr_log.size(), exp_wr.size());
    end
    foreach (exp_wr[j]) if (j < wr_log.size()) begin
      vectors++;
      if (wr_log[j] !== exp_wr[j]) begin
        miscompares++;
        $display("FAIL arst_wr%0d got %h want %h", j, wr_log[j], exp_wr[j]);
      end
    end
    vectors++;
    if (done_log.size() != 0) begin
      miscompares++;
      $display("FAIL arst_done got %0d pulses want 0", done_log.size());
    end
    clear_logs();
    t0 = cyc;
    model_load(t0);
    pulse_start();
    tick(20);
    vectors++;
    if (wr_log.size() != exp_wr.size()) begin
      miscompares++;
      $display("FAIL arst_reload_count got %0d want %0d", wr_log.size(), exp_wr.size());
    end
    foreach (exp_wr[j]) if (j < wr_log.size()) begin
      vectors++;
      if (wr_log[j] !== exp_wr[j]) begin
        miscompares++;
        $display("FAIL arst_reload_wr%0d got %h want %h", j, wr_log[j], exp_wr[j]);
      end
    end
    vectors++;
    if (done_log != exp_done) begin
      miscompares++;
      $display("FAIL arst_reload_done got %p want %p", done_log, exp_done);
    end
  endtask

  task automatic test_idle();
    clear_logs();
    tick(100);
    vectors++;
    if (wr_log.size() + done_log.size() + re_cyc.size() + busy_log.size() != 0) begin
      miscompares++;
      $display("FAIL idle_activity got we %0d done %0d re %0d busy %0d want all 0",
               wr_log.size(), done_log.size(), re_cyc.size(), busy_log.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = 16'h0;
    test_reset();
    test_basic();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
